// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable Mealy serial pattern detector with match counter
module seq_detector_param #(
  parameter int                 PAT_W   = 4,
  parameter logic [PAT_W-1:0]   PATTERN = 4'b1001,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             cnt_clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int               FW       = $clog2(PAT_W);
  localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             y_d;
  logic [PAT_W-1:0] window;

  // The current din completes the window; hist holds the PAT_W-1 bits before it.
  assign window = {hist_q, din};

  always_comb begin
    pat_d  = pat_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    sat_d  = sat_q;
    y_d    = reset & en & ~pat_load & (fill_q == FILL_MAX) & (window == pat_q);

    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      if (y_d && !overlap) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = window[PAT_W-2:0];
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
      end
    end

    // Clear wins over a same-cycle match, so that match is not counted.
    if (cnt_clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (y_d && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
      sat_d = sat_q | (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q  <= PATTERN;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      y_q    <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      y_q    <= y_d;
    end
  end

  assign y         = y_d;
  assign match_cnt = cnt_q;
  assign cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param (CNT_W 8 and 2 instances)
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset, en, din, overlap, pat_load, cnt_clr;
  logic [3:0] pat_in;
  logic       y, y_q, cnt_sat, y2, y_q2, cnt_sat2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y), .y_q(y_q), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  seq_detector_param #(.PAT_W(4), .PATTERN(4'b1001), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .din(din), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .y(y2), .y_q(y_q2), .match_cnt(match_cnt2), .cnt_sat(cnt_sat2)
  );

  typedef struct packed {
    logic       y;
    logic       yq;
    logic [7:0] cnt;
    logic       sat;
    logic [1:0] cnt2;
    logic       sat2;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic [3:0] m_pat;
  logic [2:0] m_hist;
  int         m_fill;
  int         m_cnt8, m_cnt2;
  logic       m_sat8, m_sat2, m_yq;
  logic       ovl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pat  = 4'b1001;
    m_hist = '0;
    m_fill = 0;
    m_cnt8 = 0;
    m_cnt2 = 0;
    m_sat8 = 1'b0;
    m_sat2 = 1'b0;
    m_yq   = 1'b0;
  endtask

  task automatic step(input logic i_en, input logic i_din, input logic i_load,
                      input logic [3:0] i_pat, input logic i_clr);
    exp_t e;
    logic ey;
    @(negedge clk);
    reset    = 1'b1;
    en       = i_en;
    din      = i_din;
    overlap  = ovl;
    pat_load = i_load;
    pat_in   = i_pat;
    cnt_clr  = i_clr;
    ey = i_en && !i_load && (m_fill == 3) && ({m_hist, i_din} == m_pat);
    e.y    = ey;
    e.yq   = m_yq;
    e.cnt  = 8'(m_cnt8);
    e.sat  = m_sat8;
    e.cnt2 = 2'(m_cnt2);
    e.sat2 = m_sat2;
    sb_q.push_back(e);
    m_yq = ey;
    if (i_load) begin
      m_pat  = i_pat;
      m_hist = '0;
      m_fill = 0;
    end else if (i_en) begin
      if (ey && !ovl) begin
        m_hist = '0;
        m_fill = 0;
      end else begin
        m_hist = {m_hist[1:0], i_din};
        m_fill = (m_fill < 3) ? m_fill + 1 : 3;
      end
    end
    if (i_clr) begin
      m_cnt8 = 0; m_sat8 = 1'b0;
      m_cnt2 = 0; m_sat2 = 1'b0;
    end else if (ey) begin
      if (m_cnt8 < 255) m_cnt8++;
      if (m_cnt8 == 255) m_sat8 = 1'b1;
      if (m_cnt2 < 3) m_cnt2++;
      if (m_cnt2 == 3) m_sat2 = 1'b1;
    end
  endtask

  task automatic bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, v[i], 1'b0, 4'b0, 1'b0);
  endtask

  task automatic load(input logic [3:0] p);
    step(1'b0, 1'b0, 1'b1, p, 1'b1);
  endtask

  // Idle cycle, then sample once the monitor has checked that cycle.
  task automatic settle();
    step(1'b0, 1'b0, 1'b0, 4'b0, 1'b0);
    #3;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("y", 32'(y), 32'(e.y));
        check("y_q", 32'(y_q), 32'(e.yq));
        check("match_cnt", 32'(match_cnt), 32'(e.cnt));
        check("cnt_sat", 32'(cnt_sat), 32'(e.sat));
        check("match_cnt2", 32'(match_cnt2), 32'(e.cnt2));
        check("cnt_sat2", 32'(cnt_sat2), 32'(e.sat2));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; en = 1'b0; din = 1'b0; overlap = 1'b0;
    pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0; ovl = 1'b1;
    model_reset();
    #2;
    check("rst_y", 32'(y), 32'd0);
    check("rst_y_q", 32'(y_q), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_sat", 32'(cnt_sat), 32'd0);

    // T1 overlap: matches on bits 4 and 7
    ovl = 1'b1;
    bits(16'b1001001, 7);
    settle();
    check("t1_cnt", 32'(match_cnt), 32'd2);

    // T2 non-overlap: only bit 4 matches
    ovl = 1'b0;
    load(4'b1001);
    bits(16'b1001001, 7);
    settle();
    check("t2_cnt", 32'(match_cnt), 32'd1);

    // T3 en=0 gap with toggling din
    ovl = 1'b1;
    load(4'b1001);
    bits(16'b10, 2);
    for (int i = 0; i < 3; i++) step(1'b0, i[0], 1'b0, 4'b0, 1'b0);
    bits(16'b01, 2);
    settle();
    check("t3_cnt", 32'(match_cnt), 32'd1);

    // T4 runtime reload discards partial history
    bits(16'b110, 3);
    load(4'b1101);
    bits(16'b1, 1);
    bits(16'b1101, 4);
    settle();
    check("t4_cnt", 32'(match_cnt), 32'd1);

    // T5 saturation on 2-bit counter, then clear on a match cycle
    load(4'b1001);
    bits(16'b1001001001001, 13);
    settle();
    check("t5_cnt2", 32'(match_cnt2), 32'd3);
    check("t5_sat2", 32'(cnt_sat2), 32'd1);
    check("t5_cnt8", 32'(match_cnt), 32'd4);
    bits(16'b00, 2);
    step(1'b1, 1'b1, 1'b0, 4'b0, 1'b1);
    settle();
    check("t5_clr_cnt2", 32'(match_cnt2), 32'd0);
    check("t5_clr_sat2", 32'(cnt_sat2), 32'd0);
    check("t5_clr_cnt8", 32'(match_cnt), 32'd0);

    // T6 async reset mid-stream restores PATTERN
    load(4'b1101);
    bits(16'b100, 3);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("t6_y", 32'(y), 32'd0);
    check("t6_y_q", 32'(y_q), 32'd0);
    check("t6_cnt", 32'(match_cnt), 32'd0);
    model_reset();
    bits(16'b1001, 4);
    settle();
    check("t6_cnt_after", 32'(match_cnt), 32'd1);

    @(negedge clk);
    #3;
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
